// File: rtl/pwm_timebase.sv
// PWM time-base: prescaler plus up/down/center counter with shadowed PSC/ARR and update events; outputs registered, no backpressure.
// Define PWM_TB_RCR_EN to add a repetition counter that gates over/underflow UEVs.
module pwm_timebase #(
  parameter int PSC_WIDTH = 16,
  parameter int CNT_WIDTH = 16,
  parameter int REP_WIDTH = 8
) (
  input  logic                 clk_psc_i,
  input  logic                 rst_n_i,
  input  logic                 cen_i,
  input  logic [1:0]           mode_i,
  input  logic [PSC_WIDTH-1:0] psc_preload_i,
  input  logic [CNT_WIDTH-1:0] arr_preload_i,
  input  logic                 arpe_i,
  input  logic                 udis_i,
  input  logic                 ug_i,
  input  logic [REP_WIDTH-1:0] rep_preload_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 dir_o,
  output logic                 ck_cnt_o,
  output logic                 uev_o
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_CENTER = 2'b10,
    MODE_UP_ALT = 2'b11
  } mode_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [PSC_WIDTH-1:0] PSC_ONE = PSC_WIDTH'(1);

  mode_t                mode;
  logic [PSC_WIDTH-1:0] psc_cnt;
  logic [PSC_WIDTH-1:0] psc_shadow;
  logic [CNT_WIDTH-1:0] arr_shadow;
  logic [CNT_WIDTH-1:0] arr_eff;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 dir_nxt;
  logic                 tick;
  logic                 flow;
  logic                 uev_set;

  assign mode    = mode_t'(mode_i);
  assign arr_eff = arpe_i ? arr_shadow : arr_preload_i;
  assign tick    = cen_i && (psc_cnt >= psc_shadow);

  // Prescaler restarts its phase on disable, on UG and after each tick.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      psc_cnt <= '0;
    end else if (!cen_i || ug_i || tick) begin
      psc_cnt <= '0;
    end else begin
      psc_cnt <= psc_cnt + PSC_ONE;
    end
  end

  always_comb begin
    cnt_nxt = cnt_o;
    dir_nxt = dir_o;
    flow    = 1'b0;
    if (ug_i) begin
      cnt_nxt = (mode == MODE_DOWN) ? arr_preload_i : '0;
      dir_nxt = (mode == MODE_DOWN);
    end else if (tick) begin
      if (arr_eff == '0) begin
        // Degenerate period: counter pinned at zero, every tick wraps.
        cnt_nxt = '0;
        dir_nxt = (mode == MODE_DOWN);
        flow    = 1'b1;
      end else begin
        case (mode)
          MODE_DOWN: begin
            dir_nxt = 1'b1;
            if (cnt_o == '0 || cnt_o > arr_eff) begin
              cnt_nxt = arr_eff;
              flow    = 1'b1;
            end else begin
              cnt_nxt = cnt_o - CNT_ONE;
            end
          end
          MODE_CENTER: begin
            if (!dir_o) begin
              if (cnt_o >= arr_eff) begin
                dir_nxt = 1'b1;
                cnt_nxt = arr_eff - CNT_ONE;
                flow    = 1'b1;
              end else begin
                cnt_nxt = cnt_o + CNT_ONE;
              end
            end else begin
              if (cnt_o == '0) begin
                dir_nxt = 1'b0;
                cnt_nxt = CNT_ONE;
                flow    = 1'b1;
              end else begin
                cnt_nxt = cnt_o - CNT_ONE;
              end
            end
          end
          default: begin
            dir_nxt = 1'b0;
            if (cnt_o >= arr_eff) begin
              cnt_nxt = '0;
              flow    = 1'b1;
            end else begin
              cnt_nxt = cnt_o + CNT_ONE;
            end
          end
        endcase
      end
    end
  end

`ifdef PWM_TB_RCR_EN
  logic [REP_WIDTH-1:0] rep_cnt;
  logic                 rep_zero;

  assign rep_zero = (rep_cnt == '0);
  assign uev_set  = (flow && rep_zero && !udis_i) || ug_i;

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rep_cnt <= '0;
    end else if (ug_i || (flow && rep_zero)) begin
      rep_cnt <= rep_preload_i;
    end else if (flow) begin
      rep_cnt <= rep_cnt - REP_WIDTH'(1);
    end
  end
`else
  logic unused_rep;

  assign unused_rep = ^rep_preload_i;
  assign uev_set    = (flow && !udis_i) || ug_i;
`endif

  // While stopped the shadows track the preloads so a restart uses fresh values.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      psc_shadow <= '0;
      arr_shadow <= '0;
    end else if (!cen_i || uev_set) begin
      psc_shadow <= psc_preload_i;
      arr_shadow <= arr_preload_i;
    end
  end

  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_o    <= '0;
      dir_o    <= 1'b0;
      ck_cnt_o <= 1'b0;
      uev_o    <= 1'b0;
    end else begin
      cnt_o    <= cnt_nxt;
      dir_o    <= dir_nxt;
      ck_cnt_o <= tick && !ug_i;
      uev_o    <= uev_set;
    end
  end

endmodule
